// File: rtl/run_monitor.sv
// run_monitor: multi-channel completion monitor with watchdog, skew window and result cross-check
module run_monitor #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  parameter int SKEW_MAX = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         timeout_i,
  input  logic                     check_exp_i,
  input  logic [DATA_W-1:0]        expected_i,
  input  logic [NUM_CH-1:0]        flag_i,
  input  logic [NUM_CH*DATA_W-1:0] result_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2:0]               status_o,
  output logic [DATA_W-1:0]        result_o,
  output logic [NUM_CH-1:0]        done_mask_o,
  output logic [CNT_W-1:0]         cycles_o
);
  localparam int SK_W = $clog2(SKEW_MAX + 2);
  typedef enum logic [1:0] {IDLE, RUN, COLLECT, REPORT} state_t;
  state_t                        state_q, state_d;
  logic [NUM_CH-1:0]             mask_q, mask_d;
  logic [NUM_CH-1:0][DATA_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, tmo_q, tmo_d;
  logic [SK_W-1:0]               skew_q, skew_d;
  logic                          chk_q, chk_d;
  logic [DATA_W-1:0]             exp_q, exp_d;
  logic [2:0]                    status_q, status_d;
  logic                          all_c, mism, tmo_hit, skew_hit;
  // Capture first flag per channel, advance counters, pick the run's final status on exit
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    skew_d   = skew_q;
    chk_d    = chk_q;
    exp_d    = exp_q;
    status_d = status_q;
    mism     = 1'b0;
    all_c    = 1'b0;
    tmo_hit  = 1'b0;
    skew_hit = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        tmo_d    = timeout_i;
        chk_d    = check_exp_i;
        exp_d    = expected_i;
        mask_d   = '0;
        cap_d    = '0;
        cnt_d    = '0;
        skew_d   = '0;
        status_d = 3'd0;
        state_d  = RUN;
      end
      RUN, COLLECT: begin
        cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
        skew_d = state_q == COLLECT ? skew_q + 1'b1 : '0;
        for (int k = 0; k < NUM_CH; k++)
          if (flag_i[k] && !mask_q[k]) begin
            mask_d[k] = 1'b1;
            cap_d[k]  = result_i[k*DATA_W +: DATA_W];
          end
        for (int k = 1; k < NUM_CH; k++) mism = mism | (cap_d[k] != cap_d[0]);
        all_c    = &mask_d;
        tmo_hit  = tmo_q != '0 && cnt_d == tmo_q && !all_c;
        skew_hit = state_q == COLLECT && skew_d == SK_W'(SKEW_MAX) && !all_c;
        if (all_c || tmo_hit || skew_hit) begin
          state_d  = REPORT;
          status_d = tmo_hit ? 3'd2 : skew_hit ? 3'd3 : mism ? 3'd4 :
                     (chk_q && cap_d[0] != exp_q) ? 3'd5 : 3'd1;
        end else if (state_q == RUN && |mask_d) state_d = COLLECT;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and capture registers; reset aborts any run silently
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      cap_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      skew_q   <= '0;
      chk_q    <= 1'b0;
      exp_q    <= '0;
      status_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      skew_q   <= skew_d;
      chk_q    <= chk_d;
      exp_q    <= exp_d;
      status_q <= status_d;
    end
  assign busy_o      = state_q == RUN || state_q == COLLECT;
  assign done_o      = state_q == REPORT;
  assign status_o    = status_q;
  assign result_o    = cap_q[0];
  assign done_mask_o = mask_q;
  assign cycles_o    = cnt_q;
endmodule
